// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake
// and a one-entry skid buffer, so in_ready can be registered without losing throughput.
// A flush kills every held entry. An empty or killed slot shows zero ctrl/rd as a NOP bubble.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall_cnt and kill_cnt counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned RD_W   = 5
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state_q, state_d;
    logic              rdy_q;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [RD_W-1:0]   main_rd,   skid_rd;
    logic [DATA_W-1:0] main_data, skid_data;

    logic accept, deliver;
    logic ld_main_in, ld_main_skid, ld_skid_in;

    assign accept    = in_valid & rdy_q & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign deliver   = out_valid & out_ready;
    assign in_ready  = rdy_q;

    // Bubble gating uses only the registered valid, so no input reaches an output.
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_rd   = out_valid ? main_rd   : '0;
    assign out_data = main_data;

    // Next-state and register-load decisions. A flush overrides every handshake.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = FULL;
                        ld_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (deliver && accept) begin
                        ld_main_in = 1'b1;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        state_d    = SKID;
                        ld_skid_in = 1'b1;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        state_d      = FULL;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, main/skid slots and registered in_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= EMPTY;
            rdy_q     <= 1'b0;
            main_ctrl <= '0;
            main_rd   <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != SKID);
            if (ld_main_in) begin
                main_ctrl <= in_ctrl;
                main_rd   <= in_rd;
                main_data <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_rd   <= skid_rd;
                main_data <= skid_data;
            end
            if (ld_skid_in) begin
                skid_ctrl <= in_ctrl;
                skid_rd   <= in_rd;
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W:0] kill_sum;
    logic [1:0]     held;

    // Number of live entries a flush in this cycle would discard.
    always_comb begin
        held = 2'd0;
        if (state_q == FULL) held = 2'd1;
        if (state_q == SKID) held = 2'd2;
        kill_sum = {1'b0, kill_cnt} + (CNT_W+1)'(held);
    end

    // Saturating stall and kill counters. Only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush)
                kill_cnt <= kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
        end
    end
`endif

endmodule
